ps2_player_input_mapper: RTL and testbench

Parametrised successor to the fixed two-player keyboard decode at the top level. It parses the raw PS/2 scan-code byte stream, including E0 extended and F0 break prefixes, and tracks per-player held keys. For each player it emits a one-cycle key_pressed strobe with a registered arrow code that feeds that player's processor. Player count, keymap and a per-player repeat cooldown are configurable, and it also emits a restart pulse for game reset.

---
 rtl/ps2_player_input_mapper.sv | 137 +++++++++++++
 tb/tb_ps2_player_input_mapper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_player_input_mapper.sv
// Decodes the PS/2 scan-code byte stream (E0 extended / F0 break prefixes) into
// per-player held-key bitmaps, one-cycle arrow events with a repeat cooldown, and a restart pulse.
module ps2_player_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS*45-1:0] KEYMAP = {
    9'h1FF, 9'h174, 9'h172, 9'h16B, 9'h175,
    9'h1FF, 9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int COOLDOWN = 16,
  parameter logic [7:0] RESTART_CODE = 8'h2D
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               ps2_key_data,
  input  logic                     ps2_key_pressed,
  output logic [NUM_PLAYERS-1:0]   key_pressed,
  output logic [8*NUM_PLAYERS-1:0] arrow_input,
  output logic [5*NUM_PLAYERS-1:0] held_keys,
  output logic                     restart_pulse
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } parser_state_t;

  parser_state_t r_state;
  parser_state_t w_next_state;
  logic          w_make;
  logic          w_brk;
  logic          w_ext;
  logic          r_restart;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // A byte completes a make or break only when it is neither prefix.
  always_comb begin
    w_next_state = r_state;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    w_ext        = 1'b0;
    if (ps2_key_pressed) begin
      case (r_state)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0)      w_next_state = S_EXT;
          else if (ps2_key_data == 8'hF0) w_next_state = S_BRK;
          else w_make = 1'b1;
        end
        S_EXT: begin
          if (ps2_key_data == 8'hE0)      w_next_state = S_EXT;
          else if (ps2_key_data == 8'hF0) w_next_state = S_EXT_BRK;
          else begin
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        S_BRK: begin
          if (ps2_key_data == 8'hE0)      w_next_state = S_EXT_BRK;
          else if (ps2_key_data == 8'hF0) w_next_state = S_BRK;
          else begin
            w_brk        = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        default: begin
          if ((ps2_key_data == 8'hE0) || (ps2_key_data == 8'hF0)) w_next_state = S_EXT_BRK;
          else begin
            w_brk        = 1'b1;
            w_ext        = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_restart <= 1'b0;
    else       r_restart <= w_make && !w_ext && (ps2_key_data == RESTART_CODE);
  end
  assign restart_pulse = r_restart;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [4:0]    r_held;
    logic          r_event;
    logic [7:0]    r_arrow;
    logic [CW-1:0] r_cd;
    logic          w_hit;
    logic [2:0]    w_k;

    // Descending scan so the lowest matching slot wins on duplicates.
    always_comb begin
      w_hit = 1'b0;
      w_k   = 3'd0;
      for (int k = 4; k >= 0; k--) begin
        if ((KEYMAP[p*45+k*9 +: 9] != 9'h1FF) &&
            (KEYMAP[p*45+k*9 +: 9] == {w_ext, ps2_key_data})) begin
          w_hit = 1'b1;
          w_k   = 3'(k);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_held  <= 5'd0;
        r_event <= 1'b0;
        r_arrow <= 8'd0;
        r_cd    <= '0;
      end else begin
        r_event <= 1'b0;
        if (r_cd != '0) r_cd <= r_cd - CW'(1);
        if (w_brk && w_hit) r_held[w_k] <= 1'b0;
        if (w_make && w_hit && !r_held[w_k]) begin
          r_held[w_k] <= 1'b1;
          if (r_cd == '0) begin
            r_event <= 1'b1;
            r_arrow <= 8'(w_k) + 8'd1;
            r_cd    <= CW'(COOLDOWN);
          end
        end
      end
    end

    assign key_pressed[p]         = r_event;
    assign arrow_input[8*p +: 8]  = r_arrow;
    assign held_keys[5*p +: 5]    = r_held;
  end

endmodule

// File: tb/tb_ps2_player_input_mapper.sv
// Directed bench for ps2_player_input_mapper with the default two-player keymap.
module tb_ps2_player_input_mapper;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ps2_key_data = 8'h00;
  logic        ps2_key_pressed = 1'b0;
  logic [1:0]  key_pressed;
  logic [15:0] arrow_input;
  logic [9:0]  held_keys;
  logic        restart_pulse;

  int checks = 0;
  int errors = 0;
  int p0_cnt = 0;
  int p1_cnt = 0;
  int rs_cnt = 0;

  ps2_player_input_mapper dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .key_pressed     (key_pressed),
    .arrow_input     (arrow_input),
    .held_keys       (held_keys),
    .restart_pulse   (restart_pulse)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled shortly after each rising edge.
  always @(posedge clock) begin
    #2;
    if (key_pressed[0]) p0_cnt++;
    if (key_pressed[1]) p1_cnt++;
    if (restart_pulse)  rs_cnt++;
  end

  task automatic clear_counts();
    p0_cnt = 0;
    p1_cnt = 0;
    rs_cnt = 0;
  endtask

  // Entered and left at a falling edge; strobe is high for exactly one cycle.
  task automatic strobe_byte(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    clear_counts();
  endtask

  task automatic test_reset();
    @(negedge clock);
    do_reset();
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL reset_key_pressed got %b want 00", key_pressed); end
    checks++; if (arrow_input !== 16'h0000) begin errors++; $display("FAIL reset_arrow got %h want 0000", arrow_input); end
    checks++; if (held_keys !== 10'h000) begin errors++; $display("FAIL reset_held got %h want 000", held_keys); end
    checks++; if (restart_pulse !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", restart_pulse); end
  endtask

  task automatic test_p0_make();
    strobe_byte(8'h1D);
    checks++; if (key_pressed !== 2'b01) begin errors++; $display("FAIL p0_make_kp got %b want 01", key_pressed); end
    checks++; if (arrow_input[7:0] !== 8'h01) begin errors++; $display("FAIL p0_make_arrow got %h want 01", arrow_input[7:0]); end
    checks++; if (held_keys[0] !== 1'b1) begin errors++; $display("FAIL p0_make_held got %b want 1", held_keys[0]); end
    checks++; if (arrow_input[15:8] !== 8'h00) begin errors++; $display("FAIL p0_make_p1arrow got %h want 00", arrow_input[15:8]); end
    idle(1);
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL p0_make_width got %b want 00", key_pressed); end
  endtask

  task automatic test_p1_extended();
    clear_counts();
    strobe_byte(8'hE0);
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL ext_prefix_kp got %b want 00", key_pressed); end
    strobe_byte(8'h6B);
    checks++; if (key_pressed !== 2'b10) begin errors++; $display("FAIL ext_make_kp got %b want 10", key_pressed); end
    checks++; if (arrow_input[15:8] !== 8'h02) begin errors++; $display("FAIL ext_make_arrow got %h want 02", arrow_input[15:8]); end
    checks++; if (held_keys[6] !== 1'b1) begin errors++; $display("FAIL ext_make_held got %b want 1", held_keys[6]); end
    strobe_byte(8'hE0);
    strobe_byte(8'hF0);
    strobe_byte(8'h6B);
    idle(2);
    checks++; if (held_keys[6] !== 1'b0) begin errors++; $display("FAIL ext_break_held got %b want 0", held_keys[6]); end
    checks++; if (p1_cnt !== 1) begin errors++; $display("FAIL ext_break_pulses got %0d want 1", p1_cnt); end
    checks++; if (held_keys[0] !== 1'b1) begin errors++; $display("FAIL ext_break_p0held got %b want 1", held_keys[0]); end
  endtask

  task automatic test_repeat();
    do_reset();
    strobe_byte(8'h1C);
    idle(2);
    strobe_byte(8'h1C);
    idle(3);
    checks++; if (p0_cnt !== 1) begin errors++; $display("FAIL repeat_pulses got %0d want 1", p0_cnt); end
    checks++; if (held_keys[1] !== 1'b1) begin errors++; $display("FAIL repeat_held got %b want 1", held_keys[1]); end
    checks++; if (arrow_input[7:0] !== 8'h02) begin errors++; $display("FAIL repeat_arrow got %h want 02", arrow_input[7:0]); end
  endtask

  task automatic test_cooldown();
    do_reset();
    strobe_byte(8'h1D);            // cycle 0: event, cooldown starts
    strobe_byte(8'hF0);            // cycle 1
    strobe_byte(8'h1D);            // cycle 2: break of up
    idle(2);                       // cycles 3,4
    strobe_byte(8'h1B);            // cycle 5: inside cooldown
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL cool_blocked_kp got %b want 00", key_pressed); end
    checks++; if (held_keys[2] !== 1'b1) begin errors++; $display("FAIL cool_blocked_held got %b want 1", held_keys[2]); end
    checks++; if (held_keys[0] !== 1'b0) begin errors++; $display("FAIL cool_up_released got %b want 0", held_keys[0]); end
    strobe_byte(8'hF0);            // cycle 6
    strobe_byte(8'h1B);            // cycle 7
    idle(17);                      // cycles 8..24
    checks++; if (p0_cnt !== 1) begin errors++; $display("FAIL cool_pulses got %0d want 1", p0_cnt); end
    checks++; if (arrow_input[7:0] !== 8'h01) begin errors++; $display("FAIL cool_arrow_hold got %h want 01", arrow_input[7:0]); end
    strobe_byte(8'h1B);            // cycle 25: cooldown expired
    checks++; if (key_pressed !== 2'b01) begin errors++; $display("FAIL cool_expired_kp got %b want 01", key_pressed); end
    checks++; if (arrow_input[7:0] !== 8'h03) begin errors++; $display("FAIL cool_expired_arrow got %h want 03", arrow_input[7:0]); end
  endtask

  task automatic test_restart();
    do_reset();
    strobe_byte(8'h2D);
    checks++; if (restart_pulse !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b want 1", restart_pulse); end
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL restart_kp got %b want 00", key_pressed); end
    idle(1);
    checks++; if (restart_pulse !== 1'b0) begin errors++; $display("FAIL restart_width got %b want 0", restart_pulse); end
    strobe_byte(8'h2D);
    idle(1);
    checks++; if (rs_cnt !== 2) begin errors++; $display("FAIL restart_repeat got %0d want 2", rs_cnt); end
    strobe_byte(8'hE0);
    strobe_byte(8'h2D);
    idle(1);
    checks++; if (rs_cnt !== 2) begin errors++; $display("FAIL restart_ext got %0d want 2", rs_cnt); end
    strobe_byte(8'hE0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    clear_counts();
    strobe_byte(8'h75);
    idle(2);
    checks++; if ((p0_cnt + p1_cnt) !== 0) begin errors++; $display("FAIL reset_prefix_pulses got %0d want 0", p0_cnt + p1_cnt); end
    checks++; if (held_keys !== 10'h000) begin errors++; $display("FAIL reset_prefix_held got %h want 000", held_keys); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    strobe_byte(8'h1A);
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL unmapped_kp got %b want 00", key_pressed); end
    ps2_key_data    = 8'h23;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    checks++; if (key_pressed !== 2'b01) begin errors++; $display("FAIL hold_first_kp got %b want 01", key_pressed); end
    checks++; if (arrow_input[7:0] !== 8'h04) begin errors++; $display("FAIL hold_first_arrow got %h want 04", arrow_input[7:0]); end
    @(negedge clock);
    checks++; if (key_pressed !== 2'b00) begin errors++; $display("FAIL hold_width got %b want 00", key_pressed); end
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    idle(100);
    checks++; if (p0_cnt !== 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", p0_cnt); end
    checks++; if (arrow_input[7:0] !== 8'h04) begin errors++; $display("FAIL hold_retain got %h want 04", arrow_input[7:0]); end
    checks++; if (held_keys[3] !== 1'b1) begin errors++; $display("FAIL hold_held got %b want 1", held_keys[3]); end
    strobe_byte(8'hE0);
    strobe_byte(8'h74);
    checks++; if (key_pressed !== 2'b10) begin errors++; $display("FAIL p1_right_kp got %b want 10", key_pressed); end
    checks++; if (arrow_input[15:8] !== 8'h04) begin errors++; $display("FAIL p1_right_arrow got %h want 04", arrow_input[15:8]); end
  endtask

  initial begin
    test_reset();
    test_p0_make();
    test_p1_extended();
    test_repeat();
    test_cooldown();
    test_restart();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
